// File: rtl/rr_mux_arb_n_pkg.sv
// Shared definitions for the arbitrated N-channel multiplexer.
//   MODE_FIXED / MODE_RR : arbitration policy selectors
//   sel_w()              : width of a channel index, never less than 1 bit
package rr_mux_arb_n_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_mux_arb_n_arbiter.sv
// Purely combinational N-way arbiter.
//   req_i   : per-channel request
//   ptr_i   : last granted channel (round-robin search starts one above it)
//   mode_i  : 0 = lowest index wins, 1 = round robin from ptr_i+1
//   grant_o : one-hot grant (zero when no request)
//   idx_o   : index of the granted channel (0 when no request)
//   valid_o : a grant exists
module rr_arbiter_n
   import rr_mux_arb_n_pkg::*;
#(
   parameter int N    = 4,
   parameter int SELW = sel_w(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [SELW-1:0] ptr_i,
   input  logic            mode_i,
   output logic [N-1:0]    grant_o,
   output logic [SELW-1:0] idx_o,
   output logic            valid_o
);

   int unsigned cand;

   // Candidates are visited in priority order; the first requester found wins.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      for (int k = 0; k < N; k++) begin
         if (mode_i) begin
            cand = (int'(ptr_i) + 1 + k) % N;
         end else begin
            cand = k;
         end
         if (!valid_o && req_i[cand]) begin
            valid_o       = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = SELW'(cand);
         end
      end
   end

endmodule

// File: rtl/rr_mux_arb_n.sv
// N-channel, W-bit arbitrated multiplexer with valid/ready handshakes and a
// single registered output stage (no skid buffer).
//   clock, reset : rising-edge clock, async active-high reset
//   in_data      : channel i on bits [i*W +: W]
//   in_valid     : per-channel request
//   in_ready     : per-channel accept, one-hot or zero
//   out_data     : registered data of the last accepted channel
//   out_sel      : index of the channel that produced out_data
//   out_valid    : out_data/out_sel hold a transfer
//   out_ready    : consumer accepts out_data
module rr_mux_arb_n
   import rr_mux_arb_n_pkg::*;
#(
   parameter int N    = 4,
   parameter int W    = 5,
   parameter int MODE = MODE_RR,
   parameter int SELW = sel_w(N)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   output logic [W-1:0]    out_data,
   output logic [SELW-1:0] out_sel,
   output logic            out_valid,
   input  logic            out_ready
);

   logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic [SELW-1:0] out_sel_q, out_sel_d;
   logic            out_valid_q, out_valid_d;

   logic [N-1:0]    grant;
   logic [SELW-1:0] grant_idx;
   logic            grant_any;
   logic            can_accept;
   logic            xfer;

   rr_arbiter_n #(
      .N    (N),
      .SELW (SELW)
   ) u_arb (
      .req_i   (in_valid),
      .ptr_i   (rr_ptr_q),
      .mode_i  (MODE == MODE_RR),
      .grant_o (grant),
      .idx_o   (grant_idx),
      .valid_o (grant_any)
   );

   // Gating with reset keeps requesters from seeing an accept while the
   // output register is being held clear.
   assign can_accept = !reset && (!out_valid_q || out_ready);
   assign in_ready   = grant & {N{can_accept}};
   assign xfer       = grant_any && can_accept;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[grant_idx*W +: W];
         out_sel_d   = grant_idx;
         // Fixed priority never looks at the pointer, so leave it at reset.
         if (MODE == MODE_RR) begin
            rr_ptr_d = grant_idx;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Pointer resets to N-1 so the first round-robin search begins at channel 0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         rr_ptr_q    <= SELW'(N - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb_n.sv
// Bench for rr_mux_arb_n: a round-robin instance (index 0) and a fixed-priority
// instance (index 1) share all inputs; a behavioural model tracks both.
module tb_rr_mux_arb_n;

   localparam int N = 4;
   localparam int W = 5;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic [W-1:0]   ch_data [N];
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid = '0;
   logic           out_ready = 1'b0;

   logic [N-1:0]   o_ready [2];
   logic [W-1:0]   o_data  [2];
   logic [1:0]     o_sel   [2];
   logic           o_valid [2];

   int vectors = 0;
   int errors  = 0;

   // Model state per instance
   int m_mode  [2] = '{1, 0};
   bit m_valid [2];
   int m_data  [2];
   int m_sel   [2];
   int m_ptr   [2];

   always #5 clock = ~clock;

   assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

   rr_mux_arb_n #(.N(N), .W(W), .MODE(1)) dut_rr (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(o_ready[0]), .out_data(o_data[0]), .out_sel(o_sel[0]),
      .out_valid(o_valid[0]), .out_ready(out_ready)
   );

   rr_mux_arb_n #(.N(N), .W(W), .MODE(0)) dut_fx (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(o_ready[1]), .out_data(o_data[1]), .out_sel(o_sel[1]),
      .out_valid(o_valid[1]), .out_ready(out_ready)
   );

   // Winner among requesters: fixed = lowest index; round robin = first one
   // met walking upward from the previously served channel.
   function automatic int m_grant(input int k);
      for (int step = 1; step <= N; step++) begin
         int c = (m_mode[k] != 0) ? (m_ptr[k] + step) % N : step - 1;
         if (in_valid[c]) return c;
      end
      return -1;
   endfunction

   function automatic bit m_can(input int k);
      return !reset && (!m_valid[k] || out_ready);
   endfunction

   function automatic logic [N-1:0] m_ready(input int k);
      int g = m_grant(k);
      if (g >= 0 && m_can(k)) return N'(1) << g;
      return '0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 0; m_data[k] = 0; m_sel[k] = 0; m_ptr[k] = N - 1;
      end
   endtask

   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         int g = m_grant(k);
         if (g >= 0 && m_can(k)) begin
            m_valid[k] = 1; m_data[k] = int'(ch_data[g]); m_sel[k] = g;
            if (m_mode[k] != 0) m_ptr[k] = g;
         end else if (m_valid[k] && out_ready) begin
            m_valid[k] = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      if (!reset) model_update();
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) ch_data[i] = W'(i + 7);
      reset = 1'b1;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (o_valid[k] !== 1'b0 || o_data[k] !== '0 || o_sel[k] !== '0) begin
            errors++;
            $display("FAIL reset_outputs[%0d]: got v=%b d=%h s=%0d, want 0/0/0",
                     k, o_valid[k], o_data[k], o_sel[k]);
         end
         vectors++;
         if (o_ready[k] !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready[%0d]: got %b, want 0000", k, o_ready[k]);
         end
      end
      in_valid = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_single();
      ch_data[1] = 5'h0A;
      in_valid = 4'b0010;
      out_ready = 1'b1;
      #1;
      vectors++;
      if (o_ready[0] !== 4'b0010) begin
         errors++;
         $display("FAIL single_in_ready: got %b, want 0010", o_ready[0]);
      end
      tick();
      vectors++;
      if (o_valid[0] !== 1'b1 || o_data[0] !== 5'h0A || o_sel[0] !== 2'd1) begin
         errors++;
         $display("FAIL single_out: got v=%b d=%h s=%0d, want 1/0a/1",
                  o_valid[0], o_data[0], o_sel[0]);
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int i = 0; i < N; i++) ch_data[i] = W'(i + 1);
      in_valid = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         vectors++;
         if (o_valid[0] !== 1'b1 || o_sel[0] !== 2'(i % N) || o_data[0] !== W'(i % N + 1)) begin
            errors++;
            $display("FAIL rr_seq[%0d]: got v=%b s=%0d d=%h, want 1/%0d/%0h",
                     i, o_valid[0], o_sel[0], o_data[0], i % N, i % N + 1);
         end
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      ch_data[2] = 5'h03;
      in_valid = 4'b0100;
      out_ready = 1'b1;
      tick();
      in_valid = 4'b1111;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (o_ready[0] !== 4'b0000) begin
            errors++;
            $display("FAIL bp_in_ready[%0d]: got %b, want 0000", i, o_ready[0]);
         end
         tick();
         vectors++;
         if (o_valid[0] !== 1'b1 || o_data[0] !== 5'h03 || o_sel[0] !== 2'd2) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d, want 1/03/2",
                     i, o_valid[0], o_data[0], o_sel[0]);
         end
      end
      ch_data[3] = 5'h15;
      out_ready = 1'b1;
      #1;
      vectors++;
      if (o_ready[0] !== 4'b1000) begin
         errors++;
         $display("FAIL bp_release_ready: got %b, want 1000", o_ready[0]);
      end
      tick();
      vectors++;
      if (o_valid[0] !== 1'b1 || o_sel[0] !== 2'd3 || o_data[0] !== 5'h15) begin
         errors++;
         $display("FAIL bp_release_out: got v=%b s=%0d d=%h, want 1/3/15",
                  o_valid[0], o_sel[0], o_data[0]);
      end
   endtask

   task automatic test_sparse_wrap();
      ch_data[0] = 5'h11;
      ch_data[3] = 5'h1E;
      in_valid = 4'b1001;
      out_ready = 1'b1;
      #1;
      vectors++;
      if (o_ready[0] !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_ready0: got %b, want 0001", o_ready[0]);
      end
      tick();
      vectors++;
      if (o_sel[0] !== 2'd0 || o_data[0] !== 5'h11) begin
         errors++;
         $display("FAIL wrap_sel0: got s=%0d d=%h, want 0/11", o_sel[0], o_data[0]);
      end
      #1;
      vectors++;
      if (o_ready[0] !== 4'b1000) begin
         errors++;
         $display("FAIL wrap_ready3: got %b, want 1000", o_ready[0]);
      end
      tick();
      vectors++;
      if (o_sel[0] !== 2'd3 || o_data[0] !== 5'h1E) begin
         errors++;
         $display("FAIL wrap_sel3: got s=%0d d=%h, want 3/1e", o_sel[0], o_data[0]);
      end
   endtask

   task automatic test_fixed_priority();
      in_valid = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ch_data[0] = W'(i + 2);
         tick();
         vectors++;
         if (o_valid[1] !== 1'b1 || o_sel[1] !== 2'd0 || o_data[1] !== W'(i + 2)) begin
            errors++;
            $display("FAIL fixed_ch0[%0d]: got v=%b s=%0d d=%h, want 1/0/%0h",
                     i, o_valid[1], o_sel[1], o_data[1], i + 2);
         end
      end
      in_valid = 4'b1110;
      ch_data[1] = 5'h09;
      tick();
      vectors++;
      if (o_sel[1] !== 2'd1 || o_data[1] !== 5'h09) begin
         errors++;
         $display("FAIL fixed_ch1: got s=%0d d=%h, want 1/09", o_sel[1], o_data[1]);
      end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_valid = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) ch_data[i] = W'($urandom);
         #1;
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (o_ready[k] !== m_ready(k)) begin
               errors++;
               $display("FAIL rand_ready[%0d] cyc %0d: got %b, want %b",
                        k, cyc, o_ready[k], m_ready(k));
            end
         end
         tick();
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (o_valid[k] !== m_valid[k] || o_sel[k] !== 2'(m_sel[k]) ||
                o_data[k] !== W'(m_data[k])) begin
               errors++;
               $display("FAIL rand_out[%0d] cyc %0d: got v=%b s=%0d d=%h, want v=%b s=%0d d=%0h",
                        k, cyc, o_valid[k], o_sel[k], o_data[k],
                        m_valid[k], m_sel[k], m_data[k]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      in_valid = 4'b1111;
      out_ready = 1'b1;
      ch_data[2] = 5'h1F;
      tick();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (o_valid[k] !== 1'b0 || o_data[k] !== '0 || o_sel[k] !== '0) begin
            errors++;
            $display("FAIL async_reset[%0d]: got v=%b d=%h s=%0d, want 0/0/0",
                     k, o_valid[k], o_data[k], o_sel[k]);
         end
      end
      tick();
      reset = 1'b0;
      ch_data[0] = 5'h0C;
      #1;
      vectors++;
      if (o_ready[0] !== 4'b0001) begin
         errors++;
         $display("FAIL post_reset_ready: got %b, want 0001", o_ready[0]);
      end
      tick();
      vectors++;
      if (o_valid[0] !== 1'b1 || o_sel[0] !== 2'd0 || o_data[0] !== 5'h0C) begin
         errors++;
         $display("FAIL post_reset_out: got v=%b s=%0d d=%h, want 1/0/0c",
                  o_valid[0], o_sel[0], o_data[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) ch_data[i] = '0;
      model_reset();
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_sparse_wrap();
      test_fixed_priority();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/rr_mux_arb_n.md
Name: rr_mux_arb_n

Overview:
Parametrised N-channel, W-bit arbitrated multiplexer with valid/ready handshakes and a registered output stage. It generalises the fixed 4:1 5-bit select mux. Channel selection is made internally, by fixed-priority or round-robin arbitration, rather than by an external select. Used wherever several producers (e.g. writeback or bypass sources) share one downstream consumer.

Parameters:
N, 4, number of input channels (>=2)
W, 5, data width per channel
MODE, 1, 0 = fixed priority (lowest index wins), 1 = round robin
SELW, $clog2(N), width of the granted-channel index (derived, not overridden)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_data  input  N*W  channel i occupies bits [i*W +: W]
in_valid  input  N  per-channel request
in_ready  output  N  per-channel accept (one-hot or zero)
out_data  output  W  registered selected data
out_sel  output  SELW  index of the channel that produced out_data
out_valid  output  1  out_data/out_sel hold a transfer
out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset (async, active-high): out_valid=0, out_data=0, out_sel=0, rr_ptr=N-1, so channel 0 has first priority. Reset mid-transfer drops any held output immediately. No input is accepted while reset is high.
- can_accept = !out_valid | out_ready. A single output register is used, with no skid buffer.
- Grant is combinational from in_valid and rr_ptr:
  - MODE 0: lowest set index of in_valid.
  - MODE 1: first set index searching rr_ptr+1, rr_ptr+2, … modulo N, wrapping N-1 -> 0.
- in_ready = grant & {N{can_accept}}. in_ready is one-hot when a grant exists and can_accept=1, otherwise all zero. in_ready does not depend on in_data.
- A transfer from channel g occurs when in_valid[g] & in_ready[g]. On that clock edge: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- rr_ptr <= g only on an accepted transfer. It is unchanged under backpressure or when there are no requests. In MODE 0, rr_ptr is held at its reset value and is unused.
- If out_valid & out_ready and no transfer occurs: out_valid <= 0. out_data and out_sel hold their last values.
- If out_valid & out_ready and a transfer occurs in the same cycle: the new data is loaded and out_valid stays 1. This gives full throughput of 1 transfer/cycle.
- If out_valid & !out_ready: all outputs hold and in_ready = 0.
- Latency is 1 cycle from accept to out_valid.
- Requesters must hold in_valid and in_data until accepted. The block does not depend on this for correctness.
- Round-robin fairness: any continuously asserted request is granted within N accepted transfers.

Decomposition:
- Shared include/package: MODE_FIXED=0 and MODE_RR=1 constants, plus a clog2-style SELW helper (minimum 1).
- Sub-module rr_arbiter_n: a purely combinational (req[N], ptr[SELW], mode) -> grant one-hot and grant index.
- The top level holds rr_ptr, the output register and the handshake logic.

Test Plan:
1. Single request, N=4, W=5, MODE=1: in_valid=4'b0010, ch1 data=5'h0A, out_ready=1 -> in_ready=4'b0010 that cycle. Next cycle: out_valid=1, out_data=5'h0A, out_sel=1.
2. Round robin: all in_valid=1, ch i data=i+1, out_ready=1 held for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle after the first.
3. Backpressure: out_valid=1 with data 5'h03, then out_ready=0 for 3 cycles -> in_ready=0000 and out_data stays 5'h03. Raise out_ready -> same-cycle accept of the next granted channel, out_valid stays 1.
4. Sparse wrap: after a grant to ch3 (rr_ptr=3), in_valid=4'b1001 -> grant ch0. Next accept -> ch3.
5. Fixed priority, MODE=0: all in_valid=1 for 4 accepts -> out_sel=0 every time. Drop ch0 -> ch1 granted.
6. Async reset mid-stream: assert reset between clock edges while out_valid=1 -> out_valid=0, out_data=0 and out_sel=0 immediately. After release, in_valid=4'b1111 -> first grant is ch0.
